// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: captures operands on start, adds one bit per clock, pulses done with the result.
// Optional macro SERIAL_ADDER_SUB_EN adds a sub port that turns the operation into a-b.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               carry_q;
    logic [WIDTH-2:0]   part_q;
    logic [WIDTH-1:0]   part_next;
    logic               bit_s, bit_c, last;
    logic [WIDTH-1:0]   b_load;
    logic               carry_load;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    // Subtraction is a + ~b + 1, so only the captured b and the initial carry change.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    assign bit_s     = fa_sum(a_q[0], b_q[0], carry_q);
    assign bit_c     = fa_carry(a_q[0], b_q[0], carry_q);
    assign part_next = {bit_s, part_q};
    assign last      = (cnt_q == CNT_W'(WIDTH - 1));

    assign busy = (state_q == ADD);
    assign done = (state_q == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ADD;
            ADD:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture in IDLE, shift one bit per ADD edge, publish result on the last ADD edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            part_q  <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_load;
                        carry_q <= carry_load;
                        cnt_q   <= '0;
                    end
                end
                ADD: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= bit_c;
                    part_q  <= part_next[WIDTH-1:1];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last) begin
                        sum  <= part_next;
                        cout <= bit_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): a cycle-level timing model plus a result queue.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         sub;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int total = 0;
    int bad   = 0;

    // Bench-side model state: ph=0 idle, 1..W adding, W+1 done.
    int           ph = 0;
    logic [W:0]   held = '0;
    logic [W:0]   sb_q[$];
    logic [W:0]   got;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
`ifdef SERIAL_ADDER_SUB_EN
        if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
`endif
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Sample inputs at the edge, then check outputs 1 time unit later.
    always @(posedge clock) begin
        if (reset) begin
            ph   = 0;
            held = '0;
            sb_q.delete();
        end else if (ph == 0) begin
            if (start) begin
                sb_q.push_back(model(a, b, cin, sub));
                ph = 1;
            end
        end else if (ph <= W) begin
            ph = ph + 1;
        end else begin
            ph = 0;
        end
        #1;
        chk("busy", 32'(busy), 32'((ph >= 1) && (ph <= W)));
        chk("done", 32'(done), 32'(ph == W + 1));
        if (ph == W + 1) begin
            if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
            else held = sb_q.pop_front();
        end
        got = {cout, sum};
        chk("result", 32'(got), 32'(held));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input logic s);
        a = x; b = y; cin = c; sub = s; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick(3);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // FF + 01 with operand changes during ADD
        launch(8'hFF, 8'h01, 1'b0, 1'b0);
        a = 8'h33; b = 8'h44; cin = 1'b1;
        tick(11);
        chk("ff_01_sum", 32'(sum), 32'h00);
        chk("ff_01_cout", 32'(cout), 32'd1);

        launch(8'h5A, 8'hA5, 1'b1, 1'b0);
        tick(11);
        chk("5a_a5_sum", 32'(sum), 32'h00);
        chk("5a_a5_cout", 32'(cout), 32'd1);
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        tick(4);
        chk("held_sum", 32'(sum), 32'h00);
        tick(7);
        chk("12_34_sum", 32'(sum), 32'h46);
        chk("12_34_cout", 32'(cout), 32'd0);

        // start held high: back-to-back every W+2 cycles, operands churn every cycle
        start = 1'b1;
        for (int i = 0; i < 45; i++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            tick(1);
        end
        start = 1'b0;
        tick(12);

        // reset during the 4th ADD cycle, then restart on the next edge
        launch(8'h77, 8'h11, 1'b0, 1'b0);
        tick(3);
        chk("abort_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("abort_busy0", 32'(busy), 32'd0);
        chk("abort_sum", 32'(sum), 32'h00);
        chk("abort_cout", 32'(cout), 32'd0);
        launch(8'h80, 8'h80, 1'b1, 1'b0);
        tick(11);
        chk("restart_sum", 32'(sum), 32'h01);
        chk("restart_cout", 32'(cout), 32'd1);

`ifdef SERIAL_ADDER_SUB_EN
        launch(8'h10, 8'h01, 1'b0, 1'b1);
        tick(11);
        chk("sub_10_01_sum", 32'(sum), 32'h0F);
        chk("sub_10_01_cout", 32'(cout), 32'd1);
        launch(8'h01, 8'h02, 1'b1, 1'b1);
        tick(11);
        chk("sub_01_02_sum", 32'(sum), 32'hFF);
        chk("sub_01_02_cout", 32'(cout), 32'd0);
`endif

        for (int i = 0; i < 8; i++) begin
            launch(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            tick(1 + 32'($urandom_range(9, 12)));
        end

        tick(12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
